// File: rtl/fetch_pkg.sv
// Shared types and constants for the WISC instruction fetch unit.
package fetch_pkg;

    localparam int          INSTR_W  = 16;
    localparam logic [15:0] PC_STEP  = 16'd2;

    // Decoder-facing field positions inside the instruction word
    localparam int OPC_HI   = 15;
    localparam int OPC_LO   = 11;
    localparam int FUNCT_HI = 1;
    localparam int FUNCT_LO = 0;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_ISSUE = 2'd1,
        S_HALT  = 2'd2
    } fetch_state_t;

    function automatic logic [INSTR_W-1:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    function automatic logic [INSTR_W-1:0] sext11(input logic [10:0] v);
        return {{5{v[10]}}, v};
    endfunction

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Next-PC selection: jump-displacement, register jump, taken branch or fall-through.
// Target has bit0 cleared; the raw bit0 is reported as the misalignment flag.
module pc_next
    import fetch_pkg::*;
(
    input  logic [INSTR_W-1:0] i_pc_plus2,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [INSTR_W-1:0] i_rs_val,
    input  logic               i_jump,
    input  logic               i_branch,
    input  logic               i_disp,
    input  logic               i_br_taken,
    output logic [INSTR_W-1:0] o_target,
    output logic               o_misalign
);

    logic [INSTR_W-1:0] w_raw;
    logic               w_unused_opc;

    assign w_unused_opc = ^i_instr[15:11];

    always_comb begin
        w_raw = i_pc_plus2;
        if (i_jump && i_disp)
            w_raw = i_pc_plus2 + sext11(i_instr[10:0]);
        else if (i_jump)
            w_raw = i_rs_val + sext8(i_instr[7:0]);
        else if (i_branch && i_br_taken)
            w_raw = i_pc_plus2 + sext8(i_instr[7:0]);
    end

    assign o_target   = {w_raw[INSTR_W-1:1], 1'b0};
    assign o_misalign = w_raw[0];

endmodule

// File: rtl/instr_fetch.sv
// Sequential fetch/issue unit: owns the PC, fetches one word, holds it until acked.
// Optional INSTR_FETCH_ALIGN_CHECK_EN turns an odd next-PC into a sticky err + HALT.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [15:0] PC_RESET = 16'h0000
)(
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_rdy,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               issue_valid,
    input  logic               issue_ack,
    output logic [INSTR_W-1:0] instr,
    output logic [4:0]         OpCode,
    output logic [1:0]         Funct,
    output logic [INSTR_W-1:0] pc,
    output logic [INSTR_W-1:0] pc_plus2,
    input  logic               Jump,
    input  logic               Branch,
    input  logic               disp,
    input  logic               HaltPC,
    input  logic               br_taken,
    input  logic [INSTR_W-1:0] rs_val,
    output logic               halted,
    output logic               err
);

    fetch_state_t       r_state, w_state_nxt;
    logic [INSTR_W-1:0] r_pc, r_instr;
    logic [INSTR_W-1:0] w_target;
    logic               w_misalign;
    logic               w_bad_pc;
    logic               w_accept, w_retire;

    pc_next u_pc_next (
        .i_pc_plus2 (pc_plus2),
        .i_instr    (r_instr),
        .i_rs_val   (rs_val),
        .i_jump     (Jump),
        .i_branch   (Branch),
        .i_disp     (disp),
        .i_br_taken (br_taken),
        .o_target   (w_target),
        .o_misalign (w_misalign)
    );

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    logic r_err;
    assign w_bad_pc = w_misalign;
    assign err      = r_err;

    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (w_retire && w_bad_pc)
            r_err <= 1'b1;
    end
`else
    logic w_unused_misalign;
    assign w_unused_misalign = w_misalign;
    assign w_bad_pc          = 1'b0;
    assign err               = 1'b0;
`endif

    assign w_accept = (r_state == S_FETCH) && imem_rdy;
    // A halting instruction never updates the PC, so it is not a retire.
    assign w_retire = (r_state == S_ISSUE) && issue_ack && !HaltPC;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_FETCH;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: if (imem_rdy) w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (issue_ack) begin
                    if (HaltPC || w_bad_pc) w_state_nxt = S_HALT;
                    else                    w_state_nxt = S_FETCH;
                end
            end
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        issue_valid = 1'b0;
        halted      = 1'b0;
        case (r_state)
            S_FETCH: imem_req    = 1'b1;
            S_ISSUE: issue_valid = 1'b1;
            S_HALT:  halted      = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= PC_RESET;
            r_instr <= '0;
        end else begin
            if (w_accept)
                r_instr <= imem_data;
            if (w_retire && !w_bad_pc)
                r_pc <= w_target;
        end
    end

    assign pc        = r_pc;
    assign pc_plus2  = r_pc + PC_STEP;
    assign imem_addr = r_pc;
    assign instr     = r_instr;
    assign OpCode    = r_instr[OPC_HI:OPC_LO];
    assign Funct     = r_instr[FUNCT_HI:FUNCT_LO];

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: next fetch address is predicted at each ack.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst, imem_req, imem_rdy, issue_valid, issue_ack;
    logic        Jump, Branch, disp, HaltPC, br_taken, halted, err;
    logic [15:0] imem_addr, imem_data, instr, pc, pc_plus2, rs_val;
    logic [4:0]  OpCode;
    logic [1:0]  Funct;

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] cur_pc;

    always #5 clk = ~clk;

    instr_fetch #(.PC_RESET(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdy(imem_rdy), .imem_data(imem_data),
        .issue_valid(issue_valid), .issue_ack(issue_ack),
        .instr(instr), .OpCode(OpCode), .Funct(Funct),
        .pc(pc), .pc_plus2(pc_plus2),
        .Jump(Jump), .Branch(Branch), .disp(disp), .HaltPC(HaltPC),
        .br_taken(br_taken), .rs_val(rs_val),
        .halted(halted), .err(err)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input logic j, input logic d, input logic b, input logic bt,
                       input logic h, input logic [15:0] rs);
        Jump = j; disp = d; Branch = b; br_taken = bt; HaltPC = h; rs_val = rs;
    endtask

    task automatic do_reset();
        rst = 1'b1; imem_rdy = 1'b0; issue_ack = 1'b0; imem_data = 16'h0;
        ctl(0, 0, 0, 0, 0, 16'h0);
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(16'h0000);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_valid", issue_valid, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_req", imem_req, 1'b1);
    endtask

    task automatic fetch(input logic [15:0] data, input int stall);
        int t = 0;
        while (!imem_req && t < 20) begin tick(); t++; end
        chk("fetch_req", imem_req, 1'b1);
        chk("sb_depth", 16'(exp_q.size()), 16'd1);
        cur_pc = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        chk("imem_addr", imem_addr, cur_pc);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_req", imem_req, 1'b1);
            chk("stall_addr", imem_addr, cur_pc);
            chk("stall_valid", issue_valid, 1'b0);
        end
        imem_rdy = 1'b1; imem_data = data;
        tick();
        imem_rdy = 1'b0; imem_data = 16'hDEAD;
        chk("iss_valid", issue_valid, 1'b1);
        chk("iss_req", imem_req, 1'b0);
        chk("iss_instr", instr, data);
        chk("iss_opcode", OpCode, data[15:11]);
        chk("iss_funct", Funct, data[1:0]);
        chk("iss_pc", pc, cur_pc);
        chk("iss_pc2", pc_plus2, cur_pc + 16'd2);
    endtask

    // Ack with given decoder controls; nxt is the predicted next fetch address.
    task automatic issue(input logic j, input logic d, input logic b, input logic bt,
                         input logic h, input logic [15:0] rs, input logic [15:0] nxt,
                         input logic push, input int wait_c);
        logic [15:0] held;
        held = instr;
        for (int i = 0; i < wait_c; i++) begin
            tick();
            chk("hold_valid", issue_valid, 1'b1);
            chk("hold_instr", instr, held);
        end
        ctl(j, d, b, bt, h, rs);
        issue_ack = 1'b1;
        if (push) exp_q.push_back(nxt);
        tick();
        issue_ack = 1'b0;
        // Garbage controls outside the ack cycle must be ignored
        ctl(1, 1, 1, 1, 1, 16'hFFFF);
        chk("post_ack_valid", issue_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        fetch(16'h4000, 0);
        issue(0, 0, 0, 0, 0, 16'h0, 16'h0002, 1, 0);
        fetch(16'h200C, 0);
        issue(1, 1, 0, 0, 0, 16'h0, 16'h0010, 1, 2);
        fetch(16'h60FC, 5);
        issue(0, 0, 1, 1, 0, 16'h0, 16'h000E, 1, 0);
        fetch(16'h60FC, 0);
        issue(0, 0, 1, 0, 0, 16'h0, 16'h0010, 1, 0);
        fetch(16'h2801, 0);
        issue(1, 0, 0, 0, 0, 16'h1235, 16'h1236, 1, 0);
        chk("jr_even_err", err, 1'b0);
        fetch(16'h2801, 1);
        issue(1, 0, 0, 0, 0, 16'hFFFD, 16'hFFFE, 1, 0);
        fetch(16'h2000, 0);
        issue(1, 1, 0, 0, 0, 16'h0, 16'h0000, 1, 0);
        chk("wrap_err", err, 1'b0);
        fetch(16'h601E, 0);
        issue(0, 0, 1, 1, 0, 16'h0, 16'h0020, 1, 0);
        fetch(16'h0000, 2);
        issue(1, 1, 0, 0, 1, 16'h0, 16'h0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            imem_rdy = i[0]; issue_ack = ~i[0];
            chk("halt_halted", halted, 1'b1);
            chk("halt_req", imem_req, 1'b0);
            chk("halt_valid", issue_valid, 1'b0);
            chk("halt_pc", pc, 16'h0020);
            tick();
        end
        do_reset();

        fetch(16'h2801, 0);
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
        issue(1, 0, 0, 0, 0, 16'h1234, 16'h0, 0, 0);
        chk("mis_err", err, 1'b1);
        chk("mis_halted", halted, 1'b1);
        chk("mis_pc", pc, 16'h0000);
        chk("mis_req", imem_req, 1'b0);
        tick();
        chk("mis_err_sticky", err, 1'b1);
        do_reset();
`else
        issue(1, 0, 0, 0, 0, 16'h1234, 16'h1234, 1, 0);
        chk("mis_err", err, 1'b0);
        chk("mis_halted", halted, 1'b0);
`endif

        // Reset beats a coincident ack; a late rdy is taken as the reset-PC fetch
        fetch(16'h4000, 0);
        rst = 1'b1; issue_ack = 1'b1; ctl(1, 1, 0, 0, 0, 16'h0);
        tick();
        rst = 1'b0; issue_ack = 1'b0;
        chk("rst_iss_valid", issue_valid, 1'b0);
        chk("rst_iss_pc", pc, 16'h0000);
        chk("rst_iss_req", imem_req, 1'b1);
        imem_rdy = 1'b1; imem_data = 16'h1111;
        tick();
        imem_rdy = 1'b0;
        chk("late_valid", issue_valid, 1'b1);
        chk("late_instr", instr, 16'h1111);
        chk("late_pc", pc, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
